decoder_unit: RTL and testbench
===============================

// Module: decoder_unit
// PURPOSE
//  Decode stage of the 24-bit-instruction SIMD processor. Splits one instruction into control
//  signals (ALU op, PC source, register/memory write enables, writeback mux select, immediate).
//  Outputs are registered; they drive the execute stage one clock after the instruction is presented.
// PARAMETERS
//  none (all widths are fixed by the ISA)
// PORTS
//  clk            in   1   sole clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  instruction    in   24  [23:20] opcode; fields per BEHAVIOUR
//  stall          in   1   1 = hold all outputs
//  flush          in   1   1 = load NOP
//  MemoryWrite    out  1   data-memory write strobe
//  WriteRegFrom   out  2   writeback source: 00 ALU, 01 data mem, 10 immediate, 11 pixel mem
//  RegToWrite     out  4   destination register; bit3=1 vector file, 0 scalar file
//  Immediate      out  16  zero-extended immediate / jump target
//  writeMemFrom   out  1   store data source: 0 scalar reg, 1 vector reg
//  RegWriteEnSc   out  1   scalar register-file write enable
//  RegWriteEnVec  out  1   vector register-file write enable
//  OverWriteNz    out  1   update N/Z flags from ALU result
//  PcWriteEn      out  3   000 PC+1, 001 JMP, 010 JE (Z=1), 011 JNE (Z=0), others unused
//  AluOpCode      out  3   000 ADD, 001 SUB, 010 XOR, 011 MUL, 100 RSHF, 101 LSHF, 110 INC
// BEHAVIOUR
//  - Combinational decode, then output register. Latency: exactly 1 clk.
//  - Priority per edge: rst > flush > stall > load decode.
//  - rst or flush: load NOP, i.e. every output 0.
//  - stall: all outputs keep their current value.
//  - R-type: rd=[15:12], rs1=[11:8], rs2=[7:4].
//  - I-type: rd=[15:12], Immediate={4'b0,[11:0]}.
//  - Jumps: Immediate=[15:0].
//  - RegToWrite=rd only when a register is written; otherwise 0.
//  - Immediate=0 when unused.
//  - Enables on a reg write: RegWriteEnVec=rd[3], RegWriteEnSc=~rd[3], unless stated otherwise.
//  - Opcodes:
//    0000 LOSC: WriteRegFrom=10; RegWriteEnSc=1 and RegWriteEnVec=0 regardless of rd[3].
//    0001 XOR, 0010 ADD(ECAE), 0011 SUB(DCAE), 0100 MUL, 0101 RSHF, 0110 LSHF:
//      WriteRegFrom=00, AluOpCode per table, OverWriteNz=1.
//    0111 INC: unary on rs1, AluOpCode=110, OverWriteNz=1.
//    1000 JE=010, 1001 JNE=011, 1010 JMP=001: PcWriteEn as given, no writes.
//    1011: reserved, decodes to NOP.
//    1100 STPIX: MemoryWrite=1, writeMemFrom=1, address=Immediate [11:0], source reg [15:12].
//    1101 LOPIX: WriteRegFrom=11, RegWriteEnVec=1, RegWriteEnSc=0.
//    1110 SMEM: MemoryWrite=1, writeMemFrom=[15], address=Immediate [11:0].
//    1111 LMEM: WriteRegFrom=01, I-type.
//  - Control fields not listed for an opcode are 0.
//  - Never both RegWriteEn* = 1. Never MemoryWrite together with a reg write.
// CONFIGURATION
//  DECODER_ILLEGAL_FLAG_EN
//  - Defined: extra output illegal_op (1 bit), registered with the other outputs.
//    It is 1 for opcode 1011 and cleared by rst/flush.
//  - Undefined: port absent; 1011 is a silent NOP.
// STRUCTURE
//  - Package decoder_pkg holds:
//    opcode enum (4b), ALU op constants, WriteRegFrom / PcWriteEn encodings,
//    and a packed ctrl_word_t struct covering all outputs.
//  - Sub-module decoder_ctrl_rom: combinational opcode -> ctrl_word_t.
//  - decoder_unit adds field extraction and the output register.
// TESTING
//  - rst=1 for 2 clk with any instruction -> all outputs 0.
//  - ADD 24'h209032 -> next clk:
//    AluOpCode=000, WriteRegFrom=00, RegToWrite=1001, RegWriteEnVec=1, RegWriteEnSc=0, OverWriteNz=1.
//  - LOSC 24'h00F002 -> WriteRegFrom=10, RegToWrite=1111, Immediate=2, RegWriteEnSc=1, RegWriteEnVec=0.
//  - LMEM 24'hF0F0F0 -> WriteRegFrom=01, RegToWrite=1111, Immediate=240, RegWriteEnVec=1.
//  - JNE 24'h904032 -> PcWriteEn=011, Immediate=16434, all write enables 0.
//  - flush=1 with stall=1 -> outputs 0. Then stall=1 alone -> outputs hold despite a changing instruction.
//  - Opcode 1011 -> NOP; illegal_op=1 with the macro defined.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and encodings for the 24-bit-instruction decode stage.
// Holds the opcode map, ALU / writeback / PC-source encodings and the control word.
// Optional illegal-opcode flag is controlled by DECODER_ILLEGAL_FLAG_EN (see decoder_unit).
package decoder_pkg;

    typedef enum logic [3:0] {
        OP_LOSC  = 4'h0,
        OP_XOR   = 4'h1,
        OP_ADD   = 4'h2,
        OP_SUB   = 4'h3,
        OP_MUL   = 4'h4,
        OP_RSHF  = 4'h5,
        OP_LSHF  = 4'h6,
        OP_INC   = 4'h7,
        OP_JE    = 4'h8,
        OP_JNE   = 4'h9,
        OP_JMP   = 4'hA,
        OP_RSVD  = 4'hB,
        OP_STPIX = 4'hC,
        OP_LOPIX = 4'hD,
        OP_SMEM  = 4'hE,
        OP_LMEM  = 4'hF
    } opcode_e;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_MUL  = 3'b011;
    localparam logic [2:0] ALU_RSHF = 3'b100;
    localparam logic [2:0] ALU_LSHF = 3'b101;
    localparam logic [2:0] ALU_INC  = 3'b110;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_DMEM = 2'b01;
    localparam logic [1:0] WB_IMM  = 2'b10;
    localparam logic [1:0] WB_PIX  = 2'b11;

    localparam logic [2:0] PC_NEXT = 3'b000;
    localparam logic [2:0] PC_JMP  = 3'b001;
    localparam logic [2:0] PC_JE   = 3'b010;
    localparam logic [2:0] PC_JNE  = 3'b011;

    // Which instruction field feeds the Immediate output
    typedef enum logic [1:0] {
        IMM_NONE  = 2'b00,
        IMM_ITYPE = 2'b01,
        IMM_JUMP  = 2'b10
    } imm_sel_e;

    // One field per decode-stage output; all-zero is the NOP
    typedef struct packed {
        logic        mem_write;
        logic [1:0]  wb_sel;
        logic [3:0]  rd;
        logic [15:0] imm;
        logic        wmem_src;
        logic        we_sc;
        logic        we_vec;
        logic        ovw_nz;
        logic [2:0]  pc_sel;
        logic [2:0]  alu_op;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '0;

    // Immediate is zero-extended 12 bits for I-type, the full low half for jumps
    function automatic logic [15:0] extract_imm(input logic [23:0] instr, input imm_sel_e sel);
        logic [15:0] imm;
        imm = 16'h0000;
        case (sel)
            IMM_ITYPE: imm = {4'b0000, instr[11:0]};
            IMM_JUMP:  imm = instr[15:0];
            default:   imm = 16'h0000;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/decoder_ctrl_rom.sv
// Opcode to control-word table; instruction fields are merged in by decoder_unit.
// Latency: purely combinational.
// Backpressure: none, stateless.
import decoder_pkg::*;

module decoder_ctrl_rom (
    input  opcode_e    opcode_i,
    output ctrl_word_t ctrl_o,
    output logic       reg_wr_o,
    output logic       en_by_rd_o,
    output imm_sel_e   imm_sel_o,
    output logic       wmem_by_bit15_o
`ifdef DECODER_ILLEGAL_FLAG_EN
    ,
    output logic       illegal_o
`endif
);

    // Per-opcode control template; register-file selection by rd[3] is flagged, not resolved here
    always_comb begin
        ctrl_o          = CTRL_NOP;
        reg_wr_o        = 1'b0;
        en_by_rd_o      = 1'b0;
        imm_sel_o       = IMM_NONE;
        wmem_by_bit15_o = 1'b0;
        case (opcode_i)
            OP_LOSC: begin
                ctrl_o.wb_sel = WB_IMM;
                ctrl_o.we_sc  = 1'b1;
                reg_wr_o      = 1'b1;
                imm_sel_o     = IMM_ITYPE;
            end
            OP_XOR, OP_ADD, OP_SUB, OP_MUL, OP_RSHF, OP_LSHF, OP_INC: begin
                ctrl_o.wb_sel = WB_ALU;
                ctrl_o.ovw_nz = 1'b1;
                reg_wr_o      = 1'b1;
                en_by_rd_o    = 1'b1;
                case (opcode_i)
                    OP_XOR:  ctrl_o.alu_op = ALU_XOR;
                    OP_SUB:  ctrl_o.alu_op = ALU_SUB;
                    OP_MUL:  ctrl_o.alu_op = ALU_MUL;
                    OP_RSHF: ctrl_o.alu_op = ALU_RSHF;
                    OP_LSHF: ctrl_o.alu_op = ALU_LSHF;
                    OP_INC:  ctrl_o.alu_op = ALU_INC;
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            OP_JE: begin
                ctrl_o.pc_sel = PC_JE;
                imm_sel_o     = IMM_JUMP;
            end
            OP_JNE: begin
                ctrl_o.pc_sel = PC_JNE;
                imm_sel_o     = IMM_JUMP;
            end
            OP_JMP: begin
                ctrl_o.pc_sel = PC_JMP;
                imm_sel_o     = IMM_JUMP;
            end
            OP_STPIX: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.wmem_src  = 1'b1;
                imm_sel_o        = IMM_ITYPE;
            end
            OP_LOPIX: begin
                // Pixel load always targets the vector file; the I-type field is its address
                ctrl_o.wb_sel = WB_PIX;
                ctrl_o.we_vec = 1'b1;
                reg_wr_o      = 1'b1;
                imm_sel_o     = IMM_ITYPE;
            end
            OP_SMEM: begin
                ctrl_o.mem_write = 1'b1;
                wmem_by_bit15_o  = 1'b1;
                imm_sel_o        = IMM_ITYPE;
            end
            OP_LMEM: begin
                ctrl_o.wb_sel = WB_DMEM;
                reg_wr_o      = 1'b1;
                en_by_rd_o    = 1'b1;
                imm_sel_o     = IMM_ITYPE;
            end
            default: ctrl_o = CTRL_NOP;  // OP_RSVD
        endcase
    end

`ifdef DECODER_ILLEGAL_FLAG_EN
    // Only the reserved opcode is flagged
    assign illegal_o = (opcode_i == OP_RSVD);
`endif

endmodule

// File: rtl/decoder_unit.sv
// Decode stage: instruction -> registered execute-stage control signals.
// Latency: 1 clk from instruction to outputs; rst > flush > stall > load.
// Backpressure: stall holds every output; flush loads NOP. DECODER_ILLEGAL_FLAG_EN adds illegal_op.
import decoder_pkg::*;

module decoder_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] instruction,
    input  logic        stall,
    input  logic        flush,
    output logic        MemoryWrite,
    output logic [1:0]  WriteRegFrom,
    output logic [3:0]  RegToWrite,
    output logic [15:0] Immediate,
    output logic        writeMemFrom,
    output logic        RegWriteEnSc,
    output logic        RegWriteEnVec,
    output logic        OverWriteNz,
    output logic [2:0]  PcWriteEn,
    output logic [2:0]  AluOpCode
`ifdef DECODER_ILLEGAL_FLAG_EN
    ,
    output logic        illegal_op
`endif
);

    ctrl_word_t rom_ctrl;
    ctrl_word_t ctrl_d;
    ctrl_word_t ctrl_q;
    logic       rom_reg_wr;
    logic       rom_en_by_rd;
    imm_sel_e   rom_imm_sel;
    logic       rom_wmem_by_bit15;
    logic [3:0] rd;

    // Bits [19:16] carry no information for any opcode
    logic unused_fields;
    assign unused_fields = ^instruction[19:16];

    assign rd = instruction[15:12];

`ifdef DECODER_ILLEGAL_FLAG_EN
    logic illegal_d;
    logic illegal_q;
`endif

    decoder_ctrl_rom u_rom (
        .opcode_i        (opcode_e'(instruction[23:20])),
        .ctrl_o          (rom_ctrl),
        .reg_wr_o        (rom_reg_wr),
        .en_by_rd_o      (rom_en_by_rd),
        .imm_sel_o       (rom_imm_sel),
        .wmem_by_bit15_o (rom_wmem_by_bit15)
`ifdef DECODER_ILLEGAL_FLAG_EN
        ,
        .illegal_o       (illegal_d)
`endif
    );

    // Merge instruction fields into the opcode template
    always_comb begin
        ctrl_d     = rom_ctrl;
        ctrl_d.imm = extract_imm(instruction, rom_imm_sel);
        if (rom_reg_wr) begin
            ctrl_d.rd = rd;
        end
        if (rom_en_by_rd) begin
            ctrl_d.we_vec = rd[3];
            ctrl_d.we_sc  = ~rd[3];
        end
        if (rom_wmem_by_bit15) begin
            ctrl_d.wmem_src = instruction[15];
        end
    end

    // Output register: reset and flush load NOP, stall holds
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ctrl_q <= CTRL_NOP;
        end else if (!stall) begin
            ctrl_q <= ctrl_d;
        end
    end

`ifdef DECODER_ILLEGAL_FLAG_EN
    // Illegal flag follows the same load/hold/clear rules as the control word
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            illegal_q <= 1'b0;
        end else if (!stall) begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`endif

    assign MemoryWrite   = ctrl_q.mem_write;
    assign WriteRegFrom  = ctrl_q.wb_sel;
    assign RegToWrite    = ctrl_q.rd;
    assign Immediate     = ctrl_q.imm;
    assign writeMemFrom  = ctrl_q.wmem_src;
    assign RegWriteEnSc  = ctrl_q.we_sc;
    assign RegWriteEnVec = ctrl_q.we_vec;
    assign OverWriteNz   = ctrl_q.ovw_nz;
    assign PcWriteEn     = ctrl_q.pc_sel;
    assign AluOpCode     = ctrl_q.alu_op;

endmodule

// File: tb/tb_decoder_unit.sv
// Directed bench for decoder_unit: one instruction per step, outputs checked 1 clk later.
// Expected words are hand-computed from the ISA tables.
// Builds with or without DECODER_ILLEGAL_FLAG_EN.
module tb_decoder_unit;

    logic        clk;
    logic        rst;
    logic [23:0] instruction;
    logic        stall;
    logic        flush;
    logic        MemoryWrite;
    logic [1:0]  WriteRegFrom;
    logic [3:0]  RegToWrite;
    logic [15:0] Immediate;
    logic        writeMemFrom;
    logic        RegWriteEnSc;
    logic        RegWriteEnVec;
    logic        OverWriteNz;
    logic [2:0]  PcWriteEn;
    logic [2:0]  AluOpCode;
`ifdef DECODER_ILLEGAL_FLAG_EN
    logic        illegal_op;
`endif

    int tests_run;
    int tests_failed;

    decoder_unit dut (
        .clk           (clk),
        .rst           (rst),
        .instruction   (instruction),
        .stall         (stall),
        .flush         (flush),
        .MemoryWrite   (MemoryWrite),
        .WriteRegFrom  (WriteRegFrom),
        .RegToWrite    (RegToWrite),
        .Immediate     (Immediate),
        .writeMemFrom  (writeMemFrom),
        .RegWriteEnSc  (RegWriteEnSc),
        .RegWriteEnVec (RegWriteEnVec),
        .OverWriteNz   (OverWriteNz),
        .PcWriteEn     (PcWriteEn),
        .AluOpCode     (AluOpCode)
`ifdef DECODER_ILLEGAL_FLAG_EN
        ,
        .illegal_op    (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Field order: mw, wrf, rtw, imm, wmf, sc, vec, nz, pc, alu  (33 bits)
    function automatic logic [32:0] w(input logic mw, input logic [1:0] wrf, input logic [3:0] rtw,
                                      input logic [15:0] imm, input logic wmf, input logic sc,
                                      input logic vec, input logic nz, input logic [2:0] pc,
                                      input logic [2:0] alu);
        return {mw, wrf, rtw, imm, wmf, sc, vec, nz, pc, alu};
    endfunction

    function automatic logic [32:0] observed();
        return {MemoryWrite, WriteRegFrom, RegToWrite, Immediate, writeMemFrom,
                RegWriteEnSc, RegWriteEnVec, OverWriteNz, PcWriteEn, AluOpCode};
    endfunction

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply inputs just after an edge, clock once, sample 1 time unit after the capturing edge
    task automatic step(input logic [23:0] instr, input logic s, input logic f, input logic r);
        instruction = instr;
        stall       = s;
        flush       = f;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    logic [32:0] add_word;
    logic [32:0] lopix_obs;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        instruction  = 24'h209032;
        stall        = 1'b0;
        flush        = 1'b0;
        rst          = 1'b1;
        add_word     = w(1'b0, 2'b00, 4'h9, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000);

        // Reset held 2 clk with a live ADD on the bus
        step(24'h209032, 1'b0, 1'b0, 1'b1);
        step(24'h209032, 1'b0, 1'b0, 1'b1);
        check("reset", observed(), '0);

        step(24'h209032, 1'b0, 1'b0, 1'b0);
        check("add_vec", observed(), add_word);

        step(24'h00F002, 1'b0, 1'b0, 1'b0);
        check("losc_rd3", observed(), w(1'b0, 2'b10, 4'hF, 16'd2, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000));

        step(24'hF0F0F0, 1'b0, 1'b0, 1'b0);
        check("lmem_vec", observed(), w(1'b0, 2'b01, 4'hF, 16'd240, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000));

        step(24'hF03ABC, 1'b0, 1'b0, 1'b0);
        check("lmem_sc", observed(), w(1'b0, 2'b01, 4'h3, 16'h0ABC, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000));

        step(24'h904032, 1'b0, 1'b0, 1'b0);
        check("jne", observed(), w(1'b0, 2'b00, 4'h0, 16'd16434, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000));

        step(24'h80ABCD, 1'b0, 1'b0, 1'b0);
        check("je", observed(), w(1'b0, 2'b00, 4'h0, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000));

        step(24'hA01234, 1'b0, 1'b0, 1'b0);
        check("jmp", observed(), w(1'b0, 2'b00, 4'h0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000));

        step(24'h114560, 1'b0, 1'b0, 1'b0);
        check("xor_sc", observed(), w(1'b0, 2'b00, 4'h4, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b010));

        step(24'h3A5600, 1'b0, 1'b0, 1'b0);
        check("sub_sc", observed(), w(1'b0, 2'b00, 4'h5, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b001));

        step(24'h40C000, 1'b0, 1'b0, 1'b0);
        check("mul_vec", observed(), w(1'b0, 2'b00, 4'hC, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b011));

        step(24'h502300, 1'b0, 1'b0, 1'b0);
        check("rshf", observed(), w(1'b0, 2'b00, 4'h2, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b100));

        step(24'h60F100, 1'b0, 1'b0, 1'b0);
        check("lshf", observed(), w(1'b0, 2'b00, 4'hF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b101));

        step(24'h707800, 1'b0, 1'b0, 1'b0);
        check("inc", observed(), w(1'b0, 2'b00, 4'h7, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b110));

        step(24'hC03456, 1'b0, 1'b0, 1'b0);
        check("stpix", observed(), w(1'b1, 2'b00, 4'h0, 16'h0456, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000));

        step(24'hE0A123, 1'b0, 1'b0, 1'b0);
        check("smem_vec", observed(), w(1'b1, 2'b00, 4'h0, 16'h0123, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000));

        step(24'hE07123, 1'b0, 1'b0, 1'b0);
        check("smem_sc", observed(), w(1'b1, 2'b00, 4'h0, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000));

        // Pixel load: vector enable regardless of rd[3]; Immediate excluded from the compare
        step(24'hD03055, 1'b0, 1'b0, 1'b0);
        lopix_obs = observed();
        lopix_obs[25:10] = 16'h0000;
        check("lopix", lopix_obs, w(1'b0, 2'b11, 4'h3, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000));

        step(24'hB0FFFF, 1'b0, 1'b0, 1'b0);
        check("reserved_nop", observed(), '0);
`ifdef DECODER_ILLEGAL_FLAG_EN
        check_bit("illegal_set", illegal_op, 1'b1);
        step(24'hB0FFFF, 1'b0, 1'b1, 1'b0);
        check_bit("illegal_flush", illegal_op, 1'b0);
`else
        check_bit("no_write_on_rsvd", RegWriteEnSc | RegWriteEnVec | MemoryWrite, 1'b0);
`endif

        // Flush beats stall
        step(24'h209032, 1'b0, 1'b0, 1'b0);
        check("add_before_flush", observed(), add_word);
        step(24'h00F002, 1'b1, 1'b1, 1'b0);
        check("flush_over_stall", observed(), '0);

        // Stall holds despite a changing instruction
        step(24'h209032, 1'b0, 1'b0, 1'b0);
        step(24'h00F002, 1'b1, 1'b0, 1'b0);
        check("stall_hold1", observed(), add_word);
        step(24'h904032, 1'b1, 1'b0, 1'b0);
        check("stall_hold2", observed(), add_word);

        // Reset beats stall
        step(24'h904032, 1'b1, 1'b0, 1'b1);
        check("rst_over_stall", observed(), '0);

        // Release: next instruction loads normally
        step(24'h904032, 1'b0, 1'b0, 1'b0);
        check("resume", observed(), w(1'b0, 2'b00, 4'h0, 16'h4032, 1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
